// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory arbiter: FSM states,
// requester ids and the round-robin pick function.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 15;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // One-hot grant for {D, I}; on a tie the requester not granted last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == REQ_I) ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Remembers the last granted requester and
// updates it only when the grant is actually taken.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant_r;

    // Combinational pick from the current requests and grant history
    always_comb begin
        gnt = rr_pick(req, last_grant_r);
    end

    // Grant history, reset to I so the first tie goes to D
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= REQ_I;
        end else if (en && (|gnt)) begin
            last_grant_r <= gnt[REQ_D];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between the I-cache and D-cache
// miss handlers: round-robin grant, latched request replay, ack pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_r;
    state_e            next_state_s;
    logic [1:0]        gnt_s;
    logic              grant_s;
    logic              timeout_s;
    logic              capture_s;
    logic              resp_entry_s;
    logic              grant_we_s;

    logic              id_r;
    logic              we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_re_r;
    logic              mem_we_r;
    logic              i_ack_r;
    logic              d_ack_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              busy_r;
    logic              err_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({d_req, i_req}),
        .en    (grant_s),
        .gnt   (gnt_s)
    );

    // Next-state decode; grants are only taken in IDLE with the memory ready
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        timeout_s    = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_rdy && (|gnt_s)) begin
                    grant_s      = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                if (mem_rdy) begin
                    capture_s    = ~we_r;
                    next_state_s = RESP;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign resp_entry_s = (state_r == WAIT) && (next_state_s == RESP);
    assign grant_we_s   = gnt_s[REQ_D] & d_we;

    // State, watchdog counter, busy and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            if (state_r == WAIT) begin
                wait_cnt_r <= (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + 1'b1;
            end else begin
                wait_cnt_r <= '0;
            end
            err_r <= err_r | timeout_s;
        end
    end

    // Holding registers and strobes; strobes are high for the ISSUE cycle only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r        <= REQ_I;
            we_r        <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end else if (grant_s) begin
            id_r        <= gnt_s[REQ_D];
            we_r        <= grant_we_s;
            mem_addr_r  <= gnt_s[REQ_D] ? d_addr : i_addr;
            mem_wdata_r <= grant_we_s ? d_wdata : '0;
            mem_re_r    <= ~grant_we_s;
            mem_we_r    <= grant_we_s;
        end else begin
            id_r        <= id_r;
            we_r        <= we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end
    end

    // Read data capture and ack pulse to the winner; a timeout acks without data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_rdata_r <= '0;
            d_rdata_r <= '0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
        end else begin
            i_ack_r <= resp_entry_s && (id_r == REQ_I);
            d_ack_r <= resp_entry_s && (id_r == REQ_D);
            if (capture_s && (id_r == REQ_I)) begin
                i_rdata_r <= mem_rd_data;
            end else begin
                i_rdata_r <= i_rdata_r;
            end
            if (capture_s && (id_r == REQ_D)) begin
                d_rdata_r <= mem_rd_data;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign i_ack     = i_ack_r;
    assign d_ack     = d_ack_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4-clock memory model.
// Cycle k is observed 1 time unit after posedge k; inputs set there apply to cycle k.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [14:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [14:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rd_data;
    logic        mem_rdy;
    logic        busy;
    logic        err;

    int checks;
    int failures;

    logic [31:0] mem_arr [0:32767];
    logic [1:0]  mcnt;
    logic        stall;

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rd_data (mem_rd_data),
        .mem_rdy     (mem_rdy),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: strobe seen at edge 2, rdy low in cycles 2-3, high in cycle 4
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_rdy     <= 1'b1;
            mcnt        <= 2'd0;
            mem_rd_data <= 32'h0;
            mem_arr[15'h0010] <= 32'hBEEF1234;
            mem_arr[15'h0200] <= 32'h5A5A0F0F;
        end else if (mem_re || mem_we) begin
            mem_rdy <= 1'b0;
            mcnt    <= 2'd2;
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rd_data <= mem_arr[mem_addr];
        end else if (!mem_rdy) begin
            if (mcnt > 2'd1) begin
                mcnt <= mcnt - 2'd1;
            end else begin
                mcnt <= 2'd0;
                if (!stall) mem_rdy <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if ({i_ack, d_ack, mem_re, mem_we} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {i_ack, d_ack, mem_re, mem_we}); end
        checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 111'h0) begin failures++; $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", mem_addr, mem_wdata, i_rdata, d_rdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int re_cnt = 0; int re_cyc = -1; int we_cnt = 0; int ack_cnt = 0; int ack_cyc = -1; int dack_cnt = 0;
        logic [14:0] issue_addr = 15'h0;
        logic [31:0] ack_data = 32'h0;
        logic busy1 = 1'b0;
        logic busy6 = 1'b1;
        i_addr = 15'h0010;
        d_we   = 1'b1;
        i_req  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (mem_re) begin re_cnt++; re_cyc = c; issue_addr = mem_addr; end
            if (mem_we) we_cnt++;
            if (d_ack) dack_cnt++;
            if (i_ack) begin ack_cnt++; ack_cyc = c; ack_data = i_rdata; i_req = 1'b0; end
            if (c == 1) busy1 = busy;
            if (c == 6) busy6 = busy;
        end
        d_we = 1'b0;
        checks++; if (re_cnt !== 1 || re_cyc !== 1) begin failures++; $display("FAIL rd_mem_re got=cnt %0d cyc %0d exp=cnt 1 cyc 1", re_cnt, re_cyc); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL rd_mem_we got=%0d exp=0", we_cnt); end
        checks++; if (issue_addr !== 15'h0010) begin failures++; $display("FAIL rd_addr got=%0h exp=10", issue_addr); end
        checks++; if (ack_cnt !== 1 || ack_cyc !== 5) begin failures++; $display("FAIL rd_i_ack got=cnt %0d cyc %0d exp=cnt 1 cyc 5", ack_cnt, ack_cyc); end
        checks++; if (ack_data !== 32'hBEEF1234) begin failures++; $display("FAIL rd_i_rdata got=%0h exp=beef1234", ack_data); end
        checks++; if (dack_cnt !== 0) begin failures++; $display("FAIL rd_d_ack got=%0d exp=0", dack_cnt); end
        checks++; if (busy1 !== 1'b1 || busy6 !== 1'b0) begin failures++; $display("FAIL rd_busy got=%0b%0b exp=10", busy1, busy6); end
    endtask

    task automatic test_d_write_read();
        int we_cyc = -1; int wack_cyc = -1; int rack_cyc = -1; int iack_cnt = 0;
        logic [31:0] wdata1 = 32'h0;
        logic [31:0] wdata3 = 32'h0;
        logic [31:0] rdata = 32'h0;
        d_addr  = 15'h0123;
        d_wdata = 32'hCAFEF00D;
        d_we    = 1'b1;
        d_req   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (mem_we) begin we_cyc = c; wdata1 = mem_wdata; end
            if (c == 3) wdata3 = mem_wdata;
            if (i_ack) iack_cnt++;
            if (d_ack) begin wack_cyc = c; d_req = 1'b0; end
        end
        d_we    = 1'b0;
        d_wdata = 32'h0;
        d_req   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (i_ack) iack_cnt++;
            if (d_ack) begin rack_cyc = c; rdata = d_rdata; d_req = 1'b0; end
        end
        checks++; if (we_cyc !== 1 || wdata1 !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_mem_we got=cyc %0d data %0h exp=cyc 1 data cafef00d", we_cyc, wdata1); end
        checks++; if (wdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_wdata_hold got=%0h exp=cafef00d", wdata3); end
        checks++; if (wack_cyc !== 5 || rack_cyc !== 5) begin failures++; $display("FAIL dwr_ack_cycles got=%0d/%0d exp=5/5", wack_cyc, rack_cyc); end
        checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL drd_rdata got=%0h exp=cafef00d", rdata); end
        checks++; if (iack_cnt !== 0) begin failures++; $display("FAIL dwr_i_ack got=%0d exp=0", iack_cnt); end
        checks++; if (i_rdata !== 32'hBEEF1234) begin failures++; $display("FAIL dwr_i_rdata_held got=%0h exp=beef1234", i_rdata); end
    endtask

    task automatic test_tie();
        int dack_cyc = -1; int iack_cyc = -1; int first = 1;
        logic [14:0] first_addr = 15'h0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        i_addr = 15'h0010;
        d_addr = 15'h0123;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (mem_re && first == 1) begin first_addr = mem_addr; first = 0; end
            if (d_ack) begin dack_cyc = c; d_req = 1'b0; end
            if (i_ack) begin iack_cyc = c; i_req = 1'b0; end
        end
        checks++; if (first_addr !== 15'h0123) begin failures++; $display("FAIL tie_first_addr got=%0h exp=123", first_addr); end
        checks++; if (dack_cyc !== 5 || iack_cyc !== 11) begin failures++; $display("FAIL tie_ack_cycles got=d %0d i %0d exp=d 5 i 11", dack_cyc, iack_cyc); end
        checks++; if (i_rdata !== 32'hBEEF1234 || d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL tie_rdata got=%0h/%0h exp=beef1234/cafef00d", i_rdata, d_rdata); end
    endtask

    task automatic test_back_to_back();
        int n = 0; int iack_cnt = 0;
        int   cyc [4] = '{-1, -1, -1, -1};
        logic who [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        int   exp_cyc [4] = '{5, 11, 17, 23};
        logic exp_who [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (i_ack) iack_cnt++;
            if ((i_ack || d_ack) && n < 4) begin
                cyc[n] = c; who[n] = d_ack; n++;
                if (n == 4) begin i_req = 1'b0; d_req = 1'b0; end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cyc[k] !== exp_cyc[k] || who[k] !== exp_who[k]) begin
                failures++;
                $display("FAIL b2b_ack%0d got=cyc %0d d %0b exp=cyc %0d d %0b", k, cyc[k], who[k], exp_cyc[k], exp_who[k]);
            end
        end
        checks++; if (iack_cnt !== 2) begin failures++; $display("FAIL b2b_i_count got=%0d exp=2", iack_cnt); end
    endtask

    task automatic test_reset_in_wait();
        int ack_cnt = 0; int ack_cyc = -1;
        logic busy3 = 1'b0;
        d_addr  = 15'h0300;
        d_wdata = 32'h11112222;
        d_we    = 1'b1;
        d_req   = 1'b1;
        step(); step(); step();
        busy3 = busy;
        rst_n = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        checks++; if (busy3 !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%0b%0b exp=10", busy3, busy); end
        checks++; if ({mem_addr, mem_wdata, d_rdata, i_rdata} !== 111'h0) begin failures++; $display("FAIL rstw_regs got=%0h/%0h/%0h/%0h exp=0", mem_addr, mem_wdata, d_rdata, i_rdata); end
        if (i_ack || d_ack) ack_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (i_ack || d_ack) ack_cnt++;
        end
        checks++; if (ack_cnt !== 0) begin failures++; $display("FAIL rstw_no_ack got=%0d exp=0", ack_cnt); end
        i_addr = 15'h0010;
        i_req  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (i_ack) begin ack_cyc = c; i_req = 1'b0; end
        end
        checks++; if (ack_cyc !== 5 || i_rdata !== 32'hBEEF1234) begin failures++; $display("FAIL rstw_after got=cyc %0d data %0h exp=cyc 5 data beef1234", ack_cyc, i_rdata); end
    endtask

    task automatic test_timeout();
        int ack_cnt = 0; int ack_cyc = -1;
        logic err16 = 1'b1;
        logic ack16 = 1'b1;
        logic err_ack = 1'b0;
        logic busy18 = 1'b1;
        stall  = 1'b1;
        i_addr = 15'h0200;
        i_req  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 16) begin err16 = err; ack16 = i_ack; end
            if (c == 18) busy18 = busy;
            if (i_ack) begin ack_cnt++; ack_cyc = c; err_ack = err; i_req = 1'b0; stall = 1'b0; end
        end
        stall = 1'b0;
        checks++; if (err16 !== 1'b0 || ack16 !== 1'b0) begin failures++; $display("FAIL to_early got=err %0b ack %0b exp=0 0", err16, ack16); end
        checks++; if (ack_cnt !== 1 || ack_cyc !== 17) begin failures++; $display("FAIL to_ack got=cnt %0d cyc %0d exp=cnt 1 cyc 17", ack_cnt, ack_cyc); end
        checks++; if (err_ack !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL to_err got=%0b%0b exp=11", err_ack, err); end
        checks++; if (busy18 !== 1'b0) begin failures++; $display("FAIL to_idle got=%0b exp=0", busy18); end
        checks++; if (i_rdata !== 32'hBEEF1234) begin failures++; $display("FAIL to_rdata_kept got=%0h exp=beef1234", i_rdata); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        i_req    = 1'b0;
        i_addr   = 15'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 15'h0;
        d_wdata  = 32'h0;
        test_reset();
        test_single_read();
        test_d_write_read();
        test_tie();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port controller that shares the single-ported unified memory (4-clock access, 15-bit word-pair address, 32-bit data) between the I-cache miss handler and the D-cache miss/writeback handler. Requests are arbitrated round-robin, latched, and replayed to the memory with stable address, data and strobes for the whole access. Read data is returned to the winner with a one-cycle ack pulse. The block sits between the two cache controllers and the memory; nothing else drives the memory ports.

## Interface
- ADDR_W, 15, memory address width (word-pair index)
- DATA_W, 32, memory data width
- MAX_WAIT, 15, watchdog limit in WAIT cycles before an access is abandoned

- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  I-cache read request; held high until i_ack
- i_addr  in  ADDR_W  I-cache read address
- i_ack  out  1  one-cycle pulse: I-cache read complete, i_rdata valid
- i_rdata  out  DATA_W  I-cache read data; held until next I-cache completion
- d_req  in  1  D-cache request; held high until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  D-cache address
- d_wdata  in  DATA_W  D-cache write data
- d_ack  out  1  one-cycle pulse: D-cache access complete
- d_rdata  out  DATA_W  D-cache read data; updated on D reads only
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data
- mem_rdy  in  1  memory ready; low while an access is in flight
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog flag; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if mem_rdy and any req, choose winner, latch id, addr, we and wdata into holding registers; go to ISSUE. Otherwise stay.
- Arbitration: only one req → it wins. Both → the requester not granted last wins. last_grant resets to I, so the first tie goes to D. last_grant updates at every grant.
- I-cache grants are always reads; d_we is ignored on I grants.
- ISSUE: drive mem_addr and mem_wdata from the holding registers. Assert mem_re (read) or mem_we (write) for exactly this cycle, then go to WAIT.
- WAIT: strobes low; mem_addr and mem_wdata held.
  - Increment wait_cnt each cycle.
  - On mem_rdy=1, capture mem_rd_data into the winner's rdata register (reads only) and go to RESP.
  - If wait_cnt reaches MAX_WAIT with mem_rdy still 0, set err and go to RESP with no rdata update.
- RESP: pulse the winner's ack for one cycle, then go to IDLE. Requests present in RESP are not arbitrated until the next IDLE cycle.
- A requester drops req in the cycle after it sees ack. A req still high in IDLE is a new request.
- Reset (rst_n=0 at posedge): state=IDLE, all strobes/acks/busy/err=0, rdata registers=0, mem_addr/mem_wdata=0, last_grant=I, wait_cnt=0. Reset mid-access abandons the access with no ack. The memory shares rst_n and also returns to idle.

## Timing
- Req sampled in IDLE at cycle 0. ISSUE in cycle 1: mem_re/mem_we high. WAIT in cycles 2–4 (mem_rdy = 0, 0, 1). RESP in cycle 5: ack high, rdata valid.
- Request-to-ack latency is 5 cycles, reads and writes alike.
- Back-to-back: the next grant is evaluated in cycle 6 (IDLE), so the next ISSUE is in cycle 7. Sustained throughput is one access per 6 cycles.
- mem_addr and mem_wdata are registered outputs, stable from ISSUE through WAIT. The strobes are decoded from registered state only, so there is no combinational path from req to the mem_* outputs.
- wait_cnt is $clog2(MAX_WAIT+1) bits wide and saturates.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), requester id constants (REQ_I=0, REQ_D=1), default widths.
- Sub-module rr_arb2: 2-way round-robin picker holding last_grant. Inputs: req[1:0] and a grant-enable. Output: one-hot gnt.

## Test plan
- Single I read at addr 0x0010 with memory word pair {0xBEEF,0x1234} → mem_re high in cycle 1 only; i_ack in cycle 5; i_rdata=0xBEEF1234.
- D write of 0xCAFEF00D to 0x0123, then D read of 0x0123 → each access acks 5 cycles after its req; d_rdata=0xCAFEF00D. i_ack never pulses.
- i_req and d_req both high at cycle 0 after reset → D is served first (d_ack cycle 5), then I (i_ack cycle 11). A repeated tie alternates I, D.
- D requests continuously while i_req is held → I is granted in every second access and is never starved.
- Reset asserted in WAIT → next cycle IDLE with busy=0 and no ack. A request issued after reset completes normally.
- mem_rdy held low by the bench model → err=1 after MAX_WAIT WAIT cycles, ack still pulses once, and the block returns to IDLE.
